// File: rtl/wb_arbiter2_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: bus-owner state
// encodings and the round-robin pick used whenever the bus is up for grabs.
package wb_arbiter2_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT0 = 2'd1,
        ARB_GNT1 = 2'd2
    } arb_state_t;

    // Round-robin choice between the two requesters; on a tie the master that
    // did not own the bus most recently wins.
    function automatic arb_state_t arb_pick(input logic req0, input logic req1,
                                            input logic last_grant);
        arb_state_t pick;
        pick = ARB_IDLE;
        if (req0 && req1) begin
            pick = last_grant ? ARB_GNT0 : ARB_GNT1;
        end else if (req0) begin
            pick = ARB_GNT0;
        end else if (req1) begin
            pick = ARB_GNT1;
        end
        return pick;
    endfunction

endpackage

// File: rtl/wb_arbiter2_watchdog.sv
// Stall watchdog: counts cycles the strobe waits for a slave response and
// fires a one-cycle pulse on the TIMEOUT-th unanswered cycle. TIMEOUT=0
// disables it.
module wb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic busy,
    input  logic done,
    output logic fire
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [CNT_W-1:0] wd_cnt_reg;
    logic [CNT_W-1:0] wd_cnt_next;

    assign fire = (TIMEOUT > 0) && busy && !done && (wd_cnt_reg == CNT_LAST);

    // Count stalled strobe cycles; restart on any response, idle strobe,
    // owner change or after firing. Saturates rather than wrapping.
    always_comb begin
        wd_cnt_next = wd_cnt_reg;
        if (clr || !busy || done || fire) begin
            wd_cnt_next = '0;
        end else if (wd_cnt_reg != CNT_MAX) begin
            wd_cnt_next = wd_cnt_reg + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_reg <= '0;
        end else begin
            wd_cnt_reg <= wd_cnt_next;
        end
    end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master round-robin Wishbone classic arbiter. Grants whole bus cycles
// (held while the owner keeps cyc high) and errors out stalled strobes.
module wb_arbiter2
    import wb_arbiter2_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 128,
    parameter int SEL_W   = DATA_W / 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] m0_adr_i,
    input  logic [DATA_W-1:0] m0_dat_i,
    output logic [DATA_W-1:0] m0_dat_o,
    input  logic              m0_we_i,
    input  logic [SEL_W-1:0]  m0_sel_i,
    input  logic              m0_stb_i,
    input  logic              m0_cyc_i,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    output logic              m0_rty_o,
    input  logic [ADDR_W-1:0] m1_adr_i,
    input  logic [DATA_W-1:0] m1_dat_i,
    output logic [DATA_W-1:0] m1_dat_o,
    input  logic              m1_we_i,
    input  logic [SEL_W-1:0]  m1_sel_i,
    input  logic              m1_stb_i,
    input  logic              m1_cyc_i,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic              m1_rty_o,
    output logic [ADDR_W-1:0] s_adr_o,
    output logic [DATA_W-1:0] s_dat_o,
    output logic              s_we_o,
    output logic [SEL_W-1:0]  s_sel_o,
    output logic              s_stb_o,
    output logic              s_cyc_o,
    input  logic [DATA_W-1:0] s_dat_i,
    input  logic              s_ack_i,
    input  logic              s_err_i,
    input  logic              s_rty_i
);

    arb_state_t state_reg, state_next;
    logic       last_grant_reg, last_grant_next;

    logic [1:0] own;
    logic [1:0] cyc_req;
    logic [1:0] stb_req;
    logic [1:0] ack_vec, err_vec, rty_vec;
    logic       raw_stb;
    logic       wd_fire;

    assign cyc_req = {m1_cyc_i, m0_cyc_i};
    assign stb_req = {m1_stb_i, m0_stb_i};
    assign own     = {state_reg == ARB_GNT1, state_reg == ARB_GNT0};

    // Owner holds the bus while its cyc stays high; otherwise re-arbitrate
    // directly (no IDLE bubble between owners).
    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        case (state_reg)
            ARB_GNT0: if (!m0_cyc_i) state_next = arb_pick(m0_cyc_i, m1_cyc_i, last_grant_reg);
            ARB_GNT1: if (!m1_cyc_i) state_next = arb_pick(m0_cyc_i, m1_cyc_i, last_grant_reg);
            default:  state_next = arb_pick(m0_cyc_i, m1_cyc_i, last_grant_reg);
        endcase
        if (state_next == ARB_GNT0) begin
            last_grant_next = 1'b0;
        end else if (state_next == ARB_GNT1) begin
            last_grant_next = 1'b1;
        end
    end

    // Grant state and round-robin history; reset favours m0 on the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ARB_IDLE;
            last_grant_reg <= 1'b1;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
        end
    end

    // Slave-side muxes: m1 only when it owns the bus, m0 otherwise (idle too).
    assign s_adr_o = own[1] ? m1_adr_i : m0_adr_i;
    assign s_dat_o = own[1] ? m1_dat_i : m0_dat_i;
    assign s_we_o  = own[1] ? m1_we_i  : m0_we_i;
    assign s_sel_o = own[1] ? m1_sel_i : m0_sel_i;
    assign s_cyc_o = |(own & cyc_req);
    assign raw_stb = |(own & cyc_req & stb_req);
    assign s_stb_o = raw_stb & ~wd_fire;

    wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_next != state_reg),
        .busy  (raw_stb),
        .done  (s_ack_i | s_err_i | s_rty_i),
        .fire  (wd_fire)
    );

    // Responses go to the owner only; a watchdog timeout merges into err.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_resp
            assign ack_vec[gi] = own[gi] & s_ack_i;
            assign err_vec[gi] = own[gi] & (s_err_i | wd_fire);
            assign rty_vec[gi] = own[gi] & s_rty_i;
        end
    endgenerate

    assign m0_ack_o = ack_vec[0];
    assign m0_err_o = err_vec[0];
    assign m0_rty_o = rty_vec[0];
    assign m1_ack_o = ack_vec[1];
    assign m1_err_o = err_vec[1];
    assign m1_rty_o = rty_vec[1];
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_arbiter2.sv
// Self-checking bench for wb_arbiter2 (TIMEOUT=8): an owner/timer model is
// compared against every output each cycle, plus hand-computed spot checks.
module tb_wb_arbiter2;

    localparam int TIMEOUT = 8;

    logic         clk;
    logic         rst_n;
    logic [31:0]  m0_adr_i, m1_adr_i, s_adr_o;
    logic [127:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
    logic         m0_we_i, m1_we_i, s_we_o;
    logic [15:0]  m0_sel_i, m1_sel_i, s_sel_o;
    logic         m0_stb_i, m0_cyc_i, m1_stb_i, m1_cyc_i;
    logic         m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
    logic         s_stb_o, s_cyc_o, s_ack_i, s_err_i, s_rty_i;

    int checks = 0;
    int errors = 0;

    wb_arbiter2 #(.ADDR_W(32), .DATA_W(128), .SEL_W(16), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_we_i(m0_we_i),
        .m0_sel_i(m0_sel_i), .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_we_i(m1_we_i),
        .m1_sel_i(m1_sel_i), .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    // Model: who owns the bus (0 none, 1 m0, 2 m1), who had it last, and how
    // long the current strobe has gone unanswered.
    int own_m;
    bit last_m1;
    int wait_m;

    function automatic bit raw_stb_f();
        return (own_m == 1 && m0_cyc_i && m0_stb_i) || (own_m == 2 && m1_cyc_i && m1_stb_i);
    endfunction

    function automatic bit resp_f();
        return s_ack_i || s_err_i || s_rty_i;
    endfunction

    function automatic bit fire_f();
        return raw_stb_f() && !resp_f() && (wait_m == TIMEOUT - 1);
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        int  nxt;
        bit  hold;
        if (!rst_n) begin
            own_m   <= 0;
            last_m1 <= 1'b1;
            wait_m  <= 0;
        end else begin
            hold = (own_m == 1 && m0_cyc_i) || (own_m == 2 && m1_cyc_i);
            if (hold)                      nxt = own_m;
            else if (m0_cyc_i && m1_cyc_i) nxt = last_m1 ? 1 : 2;
            else if (m0_cyc_i)             nxt = 1;
            else if (m1_cyc_i)             nxt = 2;
            else                           nxt = 0;
            if (nxt != own_m || !raw_stb_f() || resp_f() || fire_f()) wait_m <= 0;
            else wait_m <= wait_m + 1;
            own_m <= nxt;
            if (nxt != 0) last_m1 <= (nxt == 2);
        end
    end

    // Compare every output against the model on the falling edge.
    always @(negedge clk) begin : compare
        bit f;
        f = fire_f();
        chk("s_cyc_o", s_cyc_o, (own_m == 1 && m0_cyc_i) || (own_m == 2 && m1_cyc_i));
        chk("s_stb_o", s_stb_o, raw_stb_f() && !f);
        chk("s_adr_o", s_adr_o, own_m == 2 ? m1_adr_i : m0_adr_i);
        chk("s_dat_o", s_dat_o, own_m == 2 ? m1_dat_i : m0_dat_i);
        chk("s_sel_o", s_sel_o, own_m == 2 ? m1_sel_i : m0_sel_i);
        chk("s_we_o",  s_we_o,  own_m == 2 ? m1_we_i  : m0_we_i);
        chk("m0_dat_o", m0_dat_o, s_dat_i);
        chk("m1_dat_o", m1_dat_o, s_dat_i);
        chk("m0_ack_o", m0_ack_o, own_m == 1 && s_ack_i);
        chk("m0_err_o", m0_err_o, own_m == 1 && (s_err_i || f));
        chk("m0_rty_o", m0_rty_o, own_m == 1 && s_rty_i);
        chk("m1_ack_o", m1_ack_o, own_m == 2 && s_ack_i);
        chk("m1_err_o", m1_err_o, own_m == 2 && (s_err_i || f));
        chk("m1_rty_o", m1_rty_o, own_m == 2 && s_rty_i);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        m0_adr_i = 32'h10;  m1_adr_i = 32'h200;
        m0_dat_i = 128'h0A0A_0000_1111_2222_3333_4444_5555_6666;
        m1_dat_i = 128'h0B0B_7777_8888_9999_AAAA_BBBB_CCCC_DDDD;
        m0_we_i = 1'b0;     m1_we_i = 1'b1;
        m0_sel_i = 16'hFFFF; m1_sel_i = 16'h00FF;
        m0_stb_i = 0; m0_cyc_i = 0; m1_stb_i = 0; m1_cyc_i = 0;
        s_dat_i = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
        s_ack_i = 0; s_err_i = 0; s_rty_i = 0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_s_cyc", s_cyc_o, 0);
        chk("rst_s_stb", s_stb_o, 0);
        chk("rst_m0_ack", m0_ack_o, 0);
        chk("rst_m1_err", m1_err_o, 0);
        step(); rst_n = 1'b1;

        // 1: single m0 read, grant one cycle after request
        step(); m0_cyc_i = 1; m0_stb_i = 1;
        @(negedge clk); chk("t1_no_grant_yet", s_cyc_o, 0);
        step(); s_ack_i = 1;
        @(negedge clk);
        chk("t1_s_cyc", s_cyc_o, 1);
        chk("t1_s_adr", s_adr_o, 32'h10);
        chk("t1_m0_ack", m0_ack_o, 1);
        chk("t1_m1_ack", m1_ack_o, 0);
        chk("t1_rdata", m0_dat_o, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE);
        step(); s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;

        // 2: tie after reset goes to m0, then straight to m1
        step(); rst_n = 1'b0;
        step(); rst_n = 1'b1;
        step(); m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        step(); s_ack_i = 1;
        @(negedge clk);
        chk("t2_m0_wins", s_adr_o, 32'h10);
        chk("t2_m1_ack", m1_ack_o, 0);
        step(); s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        @(negedge clk); chk("t2_release_cyc", s_cyc_o, 0);
        step(); s_ack_i = 1;
        @(negedge clk);
        chk("t2_m1_adr", s_adr_o, 32'h200);
        chk("t2_m1_cyc", s_cyc_o, 1);
        chk("t2_m1_ack", m1_ack_o, 1);
        step(); s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        step();

        // 3: both keep requesting, grants alternate 0,1,0,1 (ack, rty, err, ack)
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            s_ack_i = (i == 0 || i == 3);
            s_rty_i = (i == 1);
            s_err_i = (i == 2);
            m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
            @(negedge clk);
            chk($sformatf("t3_grant%0d", i), s_adr_o, (i % 2) ? 32'h200 : 32'h10);
            step();
            s_ack_i = 0; s_rty_i = 0; s_err_i = 0;
            if (i % 2 == 0) begin m0_cyc_i = 0; m0_stb_i = 0; end
            else            begin m1_cyc_i = 0; m1_stb_i = 0; end
        end
        m0_cyc_i = 0; m0_stb_i = 0;
        step();

        // 4: m0 4-beat burst, m1 requests during beat 2 and must wait
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h40;
        for (int b = 0; b < 4; b++) begin
            step();
            m0_adr_i = 32'h40 + 32'(b * 16);
            s_ack_i = 1;
            if (b == 1) begin m1_cyc_i = 1; m1_stb_i = 1; end
            @(negedge clk);
            chk($sformatf("t4_beat%0d_adr", b), s_adr_o, 32'h40 + 32'(b * 16));
            chk($sformatf("t4_beat%0d_m1_ack", b), m1_ack_o, 0);
        end
        step(); s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        @(negedge clk); chk("t4_release_cyc", s_cyc_o, 0);
        step(); s_ack_i = 1;
        @(negedge clk); chk("t4_m1_adr", s_adr_o, 32'h200);
        step(); s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;

        // 5: slave never answers, watchdog errors the 8th strobe cycle
        step(); m0_adr_i = 32'h10; m0_cyc_i = 1; m0_stb_i = 1;
        for (int k = 1; k <= 9; k++) begin
            step();
            @(negedge clk);
            chk($sformatf("t5_stb_c%0d", k), s_stb_o, (k == 8) ? 1'b0 : 1'b1);
            chk($sformatf("t5_err_c%0d", k), m0_err_o, (k == 8) ? 1'b1 : 1'b0);
        end
        step(); s_err_i = 1;
        @(negedge clk); chk("t5_slave_err", m0_err_o, 1);
        step(); s_err_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        step();

        // 6: asynchronous reset mid-transfer, then m0 wins the next tie
        m0_cyc_i = 1; m0_stb_i = 1;
        step();
        @(negedge clk); chk("t6_granted", s_cyc_o, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0; m1_cyc_i = 1; m1_stb_i = 1;
        #1;
        chk("t6_rst_cyc", s_cyc_o, 0);
        chk("t6_rst_stb", s_stb_o, 0);
        step();
        step(); rst_n = 1'b1;
        step();
        @(negedge clk);
        chk("t6_m0_wins", s_adr_o, 32'h10);
        chk("t6_cyc", s_cyc_o, 1);
        step(); m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
